// File: rtl/uart_tx_sched_if.sv
// Requester/serializer handshake bundle for uart_tx_sched.
// slave  : scheduler side (consumes requests, drives the serializer).
// master : environment side (requesters plus serializer).
interface uart_tx_sched_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   o_grant;
  logic [N_REQ-1:0]   o_done;
  logic [7:0]         o_tx;
  logic               o_tx_start;
  logic               i_tx_busy;
  logic               i_tx_start_clear;

  modport slave (
    input  i_req, i_data, i_tx_busy, i_tx_start_clear,
    output o_grant, o_done, o_tx, o_tx_start
  );

  modport master (
    output i_req, i_data, i_tx_busy, i_tx_start_clear,
    input  o_grant, o_done, o_tx, o_tx_start
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART serializer among N_REQ byte requesters.
// Optional macro UART_TX_TIMEOUT_EN adds START/SEND watchdogs and the sticky o_err flag.
module uart_tx_sched #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned BUSY_WAIT   = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_sched_if.slave     bus,
  output logic               o_busy,
  output logic               o_err,
  input  logic               i_err_clr
);

  localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [7:0]       tx_q, tx_d;
  logic             start_q, start_d;

  logic             found;
  logic [SW-1:0]    win;
  int unsigned      idx;

`ifdef UART_TX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          tmo;
`endif

  // Round-robin winner: first pending request at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.i_req[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    grant_d = '0;
    done_d  = '0;
    tx_d    = tx_q;
    start_d = start_q;
`ifdef UART_TX_TIMEOUT_EN
    tmo     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found && !bus.i_tx_busy) begin
          state_d      = GRANT;
          sel_d        = win;
          grant_d[win] = 1'b1;
        end
      end
      GRANT: begin
        tx_d    = bus.i_data[{sel_q, 3'b000} +: 8];
        rr_d    = (sel_q == SW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        if (bus.i_tx_busy || bus.i_tx_start_clear) begin
          start_d = 1'b0;
          state_d = SEND;
        end
`ifdef UART_TX_TIMEOUT_EN
        else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          start_d        = 1'b0;
          tmo            = 1'b1;
          done_d[sel_q]  = 1'b1;
          state_d        = DONE;
        end
`endif
      end
      SEND: begin
        if (!bus.i_tx_busy) begin
          done_d[sel_q] = 1'b1;
          state_d       = DONE;
        end
`ifdef UART_TX_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tmo           = 1'b1;
          done_d[sel_q] = 1'b1;
          state_d       = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef UART_TX_TIMEOUT_EN
  // Cycles spent in the current state (cleared on every state change); clear beats set for o_err.
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    err_d = err_q;
    if (i_err_clr) err_d = 1'b0;
    else if (tmo)  err_d = 1'b1;
  end

  // Watchdog counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic cfg_unused;
  assign cfg_unused = ^{i_err_clr, 32'(BUSY_WAIT), 32'(TIMEOUT_CYC)};
  assign o_err      = 1'b0;
`endif

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      start_q <= start_d;
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_done     = done_q;
  assign bus.o_tx       = tx_q;
  assign bus.o_tx_start = start_q;
  assign o_busy         = (state_q != IDLE);

endmodule
